// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the Feather multicycle control path.
// Holds the sequencer state encoding, instruction-type and condition-code
// constants, and the ARM condition evaluation used by any block that needs
// to decide whether an instruction executes.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_BRANCH    = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  localparam logic [1:0] TYPE_DP     = 2'b00;
  localparam logic [1:0] TYPE_MEM    = 2'b01;
  localparam logic [1:0] TYPE_BRANCH = 2'b10;
  localparam logic [1:0] TYPE_UNDEF  = 2'b11;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // nzcv is packed {N,Z,C,V}. 0xF is treated as "never".
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = ~z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = ~c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = ~n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = ~v;
      COND_HI: cond_pass = c & ~z;
      COND_LS: cond_pass = ~c | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = ~z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Control/handshake bundle between the multicycle sequencer and the
// IR/PC/ALU/regfile datapath plus the shared memory port.
//   instruction_i, nzcv_i, mem_ready_i     : datapath/memory -> sequencer
//   mem_req_o, mem_addr_src_o,
//   memory_write_enable_o                  : memory port control
//   ir/pc/reg_file write enables, pc_src_o,
//   reg_write_src_o                        : datapath strobes and muxes
//   nzcv_o, fault_o                        : sequencer status
// master = sequencer side, slave = datapath/memory side.
interface multicycle_sequencer_if;
  logic [31:0] instruction_i;
  logic [3:0]  nzcv_i;
  logic        mem_ready_i;
  logic        mem_req_o;
  logic        mem_addr_src_o;
  logic        memory_write_enable_o;
  logic        ir_write_enable_o;
  logic        pc_write_enable_o;
  logic        pc_src_o;
  logic        reg_file_write_enable_o;
  logic        reg_write_src_o;
  logic [3:0]  nzcv_o;
  logic        fault_o;

  modport master (
    input  instruction_i, nzcv_i, mem_ready_i,
    output mem_req_o, mem_addr_src_o, memory_write_enable_o, ir_write_enable_o,
           pc_write_enable_o, pc_src_o, reg_file_write_enable_o, reg_write_src_o,
           nzcv_o, fault_o
  );

  modport slave (
    output instruction_i, nzcv_i, mem_ready_i,
    input  mem_req_o, mem_addr_src_o, memory_write_enable_o, ir_write_enable_o,
           pc_write_enable_o, pc_src_o, reg_file_write_enable_o, reg_write_src_o,
           nzcv_o, fault_o
  );
endinterface

// File: rtl/multicycle_sequencer_condition_check.sv
// Combinational ARM condition evaluation.
//   cond : instruction condition field [31:28]
//   nzcv : current flags {N,Z,C,V}
//   pass : 1 when the instruction should execute
module condition_check
  import multicycle_sequencer_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);
  assign pass = cond_pass(cond, nzcv);
endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle sequencer for the Feather datapath: fetch, decode, execute,
// memory, writeback, plus branch and a sticky fault state.
//   clk : clock, all state on posedge
//   rst : asynchronous active-high reset
//   bus : multicycle_sequencer_if.master (datapath strobes, memory port,
//         NZCV and fault status)
// Parameters: MEM_WAIT_MAX = wait cycles tolerated on a memory request before
// faulting; NZCV_RESET = flag register value after reset.
//
// state      | meaning
// FETCH      | request instruction word at PC; ir/pc strobe on mem_ready_i
// DECODE     | evaluate condition, dispatch on instruction type
// EXECUTE    | DP result into register file, optional flag update
// MEMORY     | data access at ALU address (load or store)
// WRITEBACK  | load data into register file
// BRANCH     | load branch target into PC
// FAULT      | memory timeout or undefined type; held until reset
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int         MEM_WAIT_MAX = 15,
  parameter logic [3:0] NZCV_RESET   = 4'b0000
)
(
  input  logic                   clk,
  input  logic                   rst,
  multicycle_sequencer_if.master bus
);

  localparam int CW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MEM_WAIT_MAX);

  state_t        state, next_state;
  logic [CW-1:0] wait_cnt;
  logic [3:0]    nzcv_q;

  // Output registers, loaded from next_state so they line up with state.
  logic mem_req_q, addr_src_q, mem_we_q, pc_we_q, pc_src_q, rf_we_q, rws_q, fault_q;

  logic [3:0] cond;
  logic [1:0] itype;
  logic       sl_bit;
  logic       cond_ok;
  logic       req_active;
  logic       timeout;
  logic       fetch_done;
  logic       unused_bits;

  assign cond        = bus.instruction_i[31:28];
  assign itype       = bus.instruction_i[27:26];
  assign sl_bit      = bus.instruction_i[20];
  assign unused_bits = ^{bus.instruction_i[25:21], bus.instruction_i[19:0]};

  condition_check u_condition_check (
    .cond (cond),
    .nzcv (nzcv_q),
    .pass (cond_ok)
  );

  assign req_active = (state == ST_FETCH) || (state == ST_MEMORY);
  // Ready on the limit cycle still wins over the timeout.
  assign timeout    = req_active && !bus.mem_ready_i && (wait_cnt == WAIT_LIMIT);
  assign fetch_done = (state == ST_FETCH) && bus.mem_ready_i && !rst;

  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH: begin
        if (bus.mem_ready_i)  next_state = ST_DECODE;
        else if (timeout)     next_state = ST_FAULT;
      end
      ST_DECODE: begin
        if (!cond_ok) begin
          next_state = ST_FETCH;
        end else begin
          case (itype)
            TYPE_DP:     next_state = ST_EXECUTE;
            TYPE_MEM:    next_state = ST_MEMORY;
            TYPE_BRANCH: next_state = ST_BRANCH;
            default:     next_state = ST_FAULT;
          endcase
        end
      end
      ST_EXECUTE:   next_state = ST_FETCH;
      ST_MEMORY: begin
        if (bus.mem_ready_i)  next_state = sl_bit ? ST_WRITEBACK : ST_FETCH;
        else if (timeout)     next_state = ST_FAULT;
      end
      ST_WRITEBACK: next_state = ST_FETCH;
      ST_BRANCH:    next_state = ST_FETCH;
      ST_FAULT:     next_state = ST_FAULT;
      default:      next_state = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_FETCH;
      wait_cnt   <= '0;
      nzcv_q     <= NZCV_RESET;
      // Reset lands in FETCH, so mem_req_q holds FETCH's value; the output
      // itself is masked while rst is high.
      mem_req_q  <= 1'b1;
      addr_src_q <= 1'b0;
      mem_we_q   <= 1'b0;
      pc_we_q    <= 1'b0;
      pc_src_q   <= 1'b0;
      rf_we_q    <= 1'b0;
      rws_q      <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state <= next_state;

      if (next_state != state)
        wait_cnt <= '0;
      else if (req_active && !bus.mem_ready_i)
        wait_cnt <= wait_cnt + CW'(1);

      if (state == ST_EXECUTE && sl_bit)
        nzcv_q <= bus.nzcv_i;

      mem_req_q  <= (next_state == ST_FETCH) || (next_state == ST_MEMORY);
      addr_src_q <= (next_state == ST_MEMORY);
      mem_we_q   <= (next_state == ST_MEMORY) && !sl_bit;
      pc_we_q    <= (next_state == ST_BRANCH);
      pc_src_q   <= (next_state == ST_BRANCH);
      rf_we_q    <= (next_state == ST_EXECUTE) || (next_state == ST_WRITEBACK);
      rws_q      <= (next_state == ST_WRITEBACK);
      fault_q    <= (next_state == ST_FAULT);
    end
  end

  assign bus.mem_req_o               = mem_req_q && !rst;
  assign bus.mem_addr_src_o          = addr_src_q;
  assign bus.memory_write_enable_o   = mem_we_q;
  assign bus.ir_write_enable_o       = fetch_done;
  assign bus.pc_write_enable_o       = pc_we_q || fetch_done;
  assign bus.pc_src_o                = pc_src_q;
  assign bus.reg_file_write_enable_o = rf_we_q;
  assign bus.reg_write_src_o         = rws_q;
  assign bus.nzcv_o                  = nzcv_q;
  assign bus.fault_o                 = fault_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_sequencer_if bus();

  multicycle_sequencer #(.MEM_WAIT_MAX(3), .NZCV_RESET(4'b0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  nzcv_in;
    int          fetch_waits;
    int          mem_waits;
    int          lat;
    int          rf;
    int          rws1;
    int          memwe;
    int          dreq;
    int          br;
    logic [3:0]  nzcv_after;
    logic        fault;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Entry: just after a negedge with the DUT in FETCH. Exit: just after the
  // negedge where the next FETCH (or FAULT) is visible.
  task automatic run_instr(input vec_t v, input string tag);
    int c, m, rf, rws1, memwe, dreq, br, stray, lat;
    logic flt;
    bit done;
    vec_t e;
    m = 0; rf = 0; rws1 = 0; memwe = 0; dreq = 0; br = 0; stray = 0;
    lat = -1; flt = 1'b0; done = 1'b0;
    exp_q.push_back(v);
    bus.instruction_i = v.instr;
    bus.nzcv_i        = v.nzcv_in;
    for (int w = 0; w <= v.fetch_waits; w++) begin
      bus.mem_ready_i = (w == v.fetch_waits);
      #1;
      check({tag, ".fetch_req"}, 32'(bus.mem_req_o), 32'd1);
      check({tag, ".fetch_src"}, 32'(bus.mem_addr_src_o), 32'd0);
      check({tag, ".fetch_ir_we"}, 32'(bus.ir_write_enable_o), 32'(w == v.fetch_waits));
      check({tag, ".fetch_pc_we"}, 32'(bus.pc_write_enable_o), 32'(w == v.fetch_waits));
      check({tag, ".fetch_pc_src"}, 32'(bus.pc_src_o), 32'd0);
      if (w < v.fetch_waits) @(negedge clk);
    end
    c = 1 + v.fetch_waits;
    while (!done) begin
      @(negedge clk);
      c++;
      if (bus.mem_req_o && bus.mem_addr_src_o) begin
        bus.mem_ready_i = (m == v.mem_waits);
        m++;
      end else begin
        bus.mem_ready_i = 1'b1;
      end
      #1;
      if (bus.fault_o) begin
        flt = 1'b1; lat = c - 1; done = 1'b1;
      end else if (bus.mem_req_o && !bus.mem_addr_src_o) begin
        lat = c - 1; done = 1'b1;
      end else begin
        rf    += int'(bus.reg_file_write_enable_o);
        rws1  += int'(bus.reg_file_write_enable_o && bus.reg_write_src_o);
        memwe += int'(bus.memory_write_enable_o);
        dreq  += int'(bus.mem_req_o);
        br    += int'(bus.pc_write_enable_o && bus.pc_src_o);
        stray += int'(bus.ir_write_enable_o);
        stray += int'(bus.memory_write_enable_o && !bus.mem_req_o);
      end
      if (!done && c > 40) begin
        n_checks++; n_fail++;
        $display("FAIL %s.timeout: no FETCH/FAULT within 40 cycles", tag);
        done = 1'b1;
      end
    end
    e = exp_q.pop_front();
    check({tag, ".latency"}, 32'(lat), 32'(e.lat));
    check({tag, ".rf_we"}, 32'(rf), 32'(e.rf));
    check({tag, ".rws_mem"}, 32'(rws1), 32'(e.rws1));
    check({tag, ".mem_we"}, 32'(memwe), 32'(e.memwe));
    check({tag, ".data_req"}, 32'(dreq), 32'(e.dreq));
    check({tag, ".branch"}, 32'(br), 32'(e.br));
    check({tag, ".stray"}, 32'(stray), 32'd0);
    check({tag, ".nzcv"}, 32'(bus.nzcv_o), 32'(e.nzcv_after));
    check({tag, ".fault"}, 32'(bus.fault_o), 32'(e.fault));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    bus.mem_ready_i = 1'b1;
    #1;
    check({tag, ".rst_req"}, 32'(bus.mem_req_o), 32'd0);
    check({tag, ".rst_fault"}, 32'(bus.fault_o), 32'd0);
    check({tag, ".rst_nzcv"}, 32'(bus.nzcv_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //            instr         nzcv_i  fw mw lat rf rws mwe dreq br nzcv    fault
    vecs.push_back('{32'h00900000, 4'b1111, 0, 0, 2, 0, 0, 0, 0, 0, 4'b0000, 1'b0}); // EQ fails
    vecs.push_back('{32'hE0900001, 4'b0100, 0, 0, 3, 1, 0, 0, 0, 0, 4'b0100, 1'b0}); // AL DP S
    vecs.push_back('{32'h00900001, 4'b1000, 0, 0, 3, 1, 0, 0, 0, 0, 4'b1000, 1'b0}); // EQ passes
    vecs.push_back('{32'h10800000, 4'b0011, 0, 0, 3, 1, 0, 0, 0, 0, 4'b1000, 1'b0}); // NE, S=0
    vecs.push_back('{32'hB0900000, 4'b0001, 2, 0, 5, 1, 0, 0, 0, 0, 4'b0001, 1'b0}); // LT, fetch waits
    vecs.push_back('{32'hC0900000, 4'b1111, 0, 0, 2, 0, 0, 0, 0, 0, 4'b0001, 1'b0}); // GT fails
    vecs.push_back('{32'hE5900000, 4'b1111, 0, 2, 6, 1, 1, 0, 3, 0, 4'b0001, 1'b0}); // load 2 waits
    vecs.push_back('{32'hE5800000, 4'b0000, 0, 0, 3, 0, 0, 1, 1, 0, 4'b0001, 1'b0}); // store
    vecs.push_back('{32'hE5800000, 4'b0000, 0, 1, 4, 0, 0, 2, 2, 0, 4'b0001, 1'b0}); // store 1 wait
    vecs.push_back('{32'hEA000000, 4'b1111, 0, 0, 3, 0, 0, 0, 0, 1, 4'b0001, 1'b0}); // branch
    vecs.push_back('{32'hF0900000, 4'b1111, 0, 0, 2, 0, 0, 0, 0, 0, 4'b0001, 1'b0}); // NV
    vecs.push_back('{32'h0A000000, 4'b1111, 0, 0, 2, 0, 0, 0, 0, 0, 4'b0001, 1'b0}); // EQ branch fails
    vecs.push_back('{32'hE5900000, 4'b1111, 0, 3, 7, 1, 1, 0, 4, 0, 4'b0001, 1'b0}); // ready on limit
    vecs.push_back('{32'h50900000, 4'b1010, 0, 0, 3, 1, 0, 0, 0, 0, 4'b1010, 1'b0}); // PL
    vecs.push_back('{32'h80900000, 4'b0110, 0, 0, 3, 1, 0, 0, 0, 0, 4'b0110, 1'b0}); // HI
    vecs.push_back('{32'h90800000, 4'b1111, 0, 0, 3, 1, 0, 0, 0, 0, 4'b0110, 1'b0}); // LS, S=0
    vecs.push_back('{32'hD5900000, 4'b1111, 0, 0, 4, 1, 1, 0, 1, 0, 4'b0110, 1'b0}); // LE load

    rst = 1'b1;
    bus.instruction_i = 32'h0;
    bus.nzcv_i        = 4'h0;
    bus.mem_ready_i   = 1'b1;
    #12;
    check("reset.mem_req", 32'(bus.mem_req_o), 32'd0);
    check("reset.ir_we", 32'(bus.ir_write_enable_o), 32'd0);
    check("reset.pc_we", 32'(bus.pc_write_enable_o), 32'd0);
    check("reset.rf_we", 32'(bus.reg_file_write_enable_o), 32'd0);
    check("reset.nzcv", 32'(bus.nzcv_o), 32'd0);
    check("reset.fault", 32'(bus.fault_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      run_instr(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a data request: the request drops at once and
    // the flags return to their reset value.
    bus.instruction_i = 32'hE5900000;
    bus.mem_ready_i   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    #1;
    check("midrst.in_mem", 32'({bus.mem_req_o, bus.mem_addr_src_o}), 32'b11);
    #2 rst = 1'b1;
    #1;
    check("midrst.req_drop", 32'(bus.mem_req_o), 32'd0);
    check("midrst.ir_we", 32'(bus.ir_write_enable_o), 32'd0);
    check("midrst.nzcv", 32'(bus.nzcv_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst.refetch", 32'({bus.mem_req_o, bus.mem_addr_src_o}), 32'b10);

    // Data request never acknowledged: FAULT after four request cycles.
    run_instr('{32'hE5800000, 4'b1111, 0, 99, 6, 0, 0, 4, 4, 0, 4'b0000, 1'b1}, "memto");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.mem_ready_i = 1'b1;
      #1;
      check("memto.sticky", 32'(bus.fault_o), 32'd1);
      check("memto.quiet", 32'({bus.mem_req_o, bus.reg_file_write_enable_o,
                                bus.pc_write_enable_o, bus.ir_write_enable_o}), 32'd0);
    end
    do_reset("memto");

    // Instruction fetch never acknowledged.
    bus.mem_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("fetchto.req", 32'(bus.mem_req_o), 32'd1);
      check("fetchto.nofault", 32'(bus.fault_o), 32'd0);
      @(negedge clk);
    end
    #1;
    check("fetchto.fault", 32'(bus.fault_o), 32'd1);
    check("fetchto.req_off", 32'(bus.mem_req_o), 32'd0);
    do_reset("fetchto");

    // Undefined instruction type.
    run_instr('{32'hEC000000, 4'b1111, 0, 0, 2, 0, 0, 0, 0, 0, 4'b0000, 1'b1}, "undef");
    do_reset("undef");
    #1;
    check("final.fetch", 32'({bus.mem_req_o, bus.mem_addr_src_o}), 32'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
